// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier and its
// helper blocks: controller states, default geometry and a width helper.
package mult_pkg;

   localparam int A_W_DEF = 4;
   localparam int B_W_DEF = 3;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/add_sub_n.sv
// N-bit ripple add/subtract built from full-adder cells.
// M=0 adds, M=1 subtracts (b inverted per bit, M used as carry-in).
module add_sub_n
   import mult_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         M,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] s,
   output logic         c_out,
   output logic         v
);

   logic [N:0] c;

   assign c[0] = M;

   for (genvar gi = 0; gi < N; gi++) begin : g_fa
      logic bx;
      assign bx        = b[gi] ^ M;
      assign s[gi]     = a[gi] ^ bx ^ c[gi];
      assign c[gi + 1] = (a[gi] & bx) | (c[gi] & (a[gi] ^ bx));
   end

   assign c_out = c[N];
   assign v     = c[N] ^ c[N-1];

endmodule

// File: rtl/mult_seq_ctrl.sv
// Iterative unsigned A_W x B_W multiplier: one multiplier bit per clock through
// a single A_W-bit adder, with ready/start input and valid/ready output handshakes.
module mult_seq_ctrl
   import mult_pkg::*;
#(
   parameter  int A_W = A_W_DEF,
   parameter  int B_W = B_W_DEF,
   localparam int P_W = A_W + B_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [A_W-1:0] mcand,
   input  logic [B_W-1:0] mplier,
   output logic           in_ready,
   output logic           busy,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [P_W-1:0] product
);

   localparam int IW = (clog2(B_W) > 0) ? clog2(B_W) : 1;

   state_t         state;
   state_t         state_next;
   logic [A_W-1:0] mcand_r;
   logic [A_W:0]   acc;
   logic [B_W-1:0] q;
   logic [IW-1:0]  iter;

   logic [A_W-1:0] addend;
   logic [A_W-1:0] sum;
   logic           carry;
   logic           last_iter;
   logic [P_W:0]   shifted;
   logic           v_unused;
   logic           acc_msb_unused;

   assign addend = q[0] ? mcand_r : '0;

   add_sub_n #(.N(A_W)) u_adder (
      .M     (1'b0),
      .a     (acc[A_W-1:0]),
      .b     (addend),
      .s     (sum),
      .c_out (carry),
      .v     (v_unused)
   );

   // {carry, sum, q} shifted right once: top A_W+1 bits are the new acc,
   // low B_W bits the new q, and the low P_W bits the finished product.
   assign shifted        = {carry, sum, q} >> 1;
   assign last_iter      = (iter == IW'(B_W - 1));
   assign acc_msb_unused = acc[A_W];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      busy       = 1'b0;
      out_valid  = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (start) state_next = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last_iter) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand_r <= '0;
         acc     <= '0;
         q       <= '0;
         iter    <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand_r <= mcand;
                  q       <= mplier;
                  acc     <= '0;
                  iter    <= '0;
               end
            end
            RUN: begin
               acc  <= shifted[P_W:B_W];
               q    <= shifted[B_W-1:0];
               iter <= iter + 1'b1;
               if (last_iter) product <= shifted[P_W-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed table, reset-abort sequence,
// exhaustive back-to-back sweep and randomized handshakes against a.b arithmetic.
module tb_mult_seq_ctrl;
   import mult_pkg::*;

   localparam int A_W = 4;
   localparam int B_W = 3;
   localparam int P_W = A_W + B_W;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic           out_ready = 1'b0;
   logic [A_W-1:0] mcand = '0;
   logic [B_W-1:0] mplier = '0;
   logic           in_ready;
   logic           busy;
   logic           out_valid;
   logic [P_W-1:0] product;

   int pass_cnt = 0;
   int total_cnt = 0;
   int cycle = 0;
   int last_accept = -1;

   typedef struct {
      logic [A_W-1:0] a;
      logic [B_W-1:0] b;
      int             stall;
      bit             noise;
      int             exp;
   } vec_t;

   vec_t vecs[6];

   mult_seq_ctrl #(.A_W(A_W), .B_W(B_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mcand     (mcand),
      .mplier    (mplier),
      .in_ready  (in_ready),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   function automatic int model(input int a, input int b);
      return a * b;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
   endtask

   // One full transaction: accept, run, optional DONE stall, drain to IDLE.
   task automatic do_op(input logic [A_W-1:0] a, input logic [B_W-1:0] b, input int stall,
                        input bit noise, input bit hold_ready, input int exp);
      int n;
      int lat;
      int t_acc;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", 32'(in_ready), 1);
      mcand     = a;
      mplier    = b;
      start     = 1'b1;
      out_ready = hold_ready;
      t_acc     = cycle;
      if (hold_ready && last_accept >= 0) chk("accept_interval", t_acc - last_accept, B_W + 2);
      last_accept = t_acc;
      @(negedge clk);
      chk("busy_after_accept", 32'(busy), 1);
      chk("in_ready_in_run", 32'(in_ready), 0);
      start = noise;
      if (noise) begin
         mcand  = ~a;
         mplier = ~b;
      end
      lat = 0;
      while (!out_valid && lat < 20) begin
         if (noise) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, B_W);
      chk("product", 32'(product), exp);
      out_ready = (stall == 0);
      for (int i = 0; i < stall; i++) begin
         if (noise) begin
            start  = 1'($urandom_range(0, 1));
            mcand  = 4'($urandom);
            mplier = 3'($urandom);
         end
         @(negedge clk);
         chk("stall_valid", 32'(out_valid), 1);
         chk("stall_product", 32'(product), exp);
         chk("stall_in_ready", 32'(in_ready), 0);
      end
      out_ready = 1'b1;
      if (noise) start = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      out_ready = hold_ready;
      chk("idle_valid", 32'(out_valid), 0);
      chk("idle_in_ready", 32'(in_ready), 1);
      chk("idle_busy", 32'(busy), 0);
      chk("held_product", 32'(product), exp);
      $display("op a=%0d b=%0d stall=%0d noise=%0d latency=%0d product=%0d expected=%0d",
               a, b, stall, noise, lat, product, exp);
   endtask

   initial begin
      vecs[0] = '{a: 4'd15, b: 3'd7, stall: 0,  noise: 1'b0, exp: 105};
      vecs[1] = '{a: 4'd0,  b: 3'd5, stall: 0,  noise: 1'b0, exp: 0};
      vecs[2] = '{a: 4'd9,  b: 3'd0, stall: 0,  noise: 1'b0, exp: 0};
      vecs[3] = '{a: 4'd9,  b: 3'd5, stall: 10, noise: 1'b1, exp: 45};
      vecs[4] = '{a: 4'd13, b: 3'd6, stall: 2,  noise: 1'b1, exp: 78};
      vecs[5] = '{a: 4'd1,  b: 3'd1, stall: 1,  noise: 1'b0, exp: 1};

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_in_ready", 32'(in_ready), 1);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_out_valid", 32'(out_valid), 0);
      chk("reset_product", 32'(product), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].stall, vecs[i].noise, 1'b0, vecs[i].exp);
      end

      // Abort 13x6 with reset in its second RUN cycle.
      mcand  = 4'd13;
      mplier = 3'd6;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("abort_busy_before", 32'(busy), 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_in_ready", 32'(in_ready), 1);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_out_valid", 32'(out_valid), 0);
      chk("abort_product", 32'(product), 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_no_completion", 32'(out_valid), 0);
      end
      do_op(4'd3, 3'd3, 0, 1'b0, 1'b0, 9);

      last_accept = -1;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 8; b++) begin
            do_op(4'(a), 3'(b), 0, 1'b0, 1'b1, model(a, b));
         end
      end
      out_ready = 1'b0;

      for (int i = 0; i < 30; i++) begin
         int ra;
         int rb;
         ra = int'($urandom_range(0, 15));
         rb = int'($urandom_range(0, 7));
         do_op(4'(ra), 3'(rb), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0,
               model(ra, rb));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
